tilelink_slave_mem: RTL and testbench

TileLink-UL responder (slave) with a small on-chip word memory. It sits at the far end of the A/D channels driven by `tilelink_master_top_new_updated` and accepts Get, PutFullData and PutPartialData requests on channel A. It returns AccessAckData or AccessAck on channel D. One transaction is outstanding at a time, and response latency is programmable, so the master can be exercised with both immediate and delayed responses.

---
 rtl/tl_pkg.sv | 27 ++
 rtl/tl_slave_mem_array.sv | 35 +++
 rtl/tilelink_slave_mem.sv | 155 +++++++++++++++
 tb/tb_tilelink_slave_mem.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants: field widths, A/D opcodes and the
// responder FSM state encoding.
package tl_pkg;

    localparam int TL_ADDR_W   = 64;
    localparam int TL_DATA_W   = 64;
    localparam int TL_STRB_W   = TL_DATA_W / 8;
    localparam int TL_SOURCE_W = 3;
    localparam int TL_SINK_W   = 3;
    localparam int TL_OPCODE_W = 3;
    localparam int TL_PARAM_W  = 3;
    localparam int TL_SIZE_W   = 8;

    localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
    localparam logic [2:0] GET_A              = 3'd4;

    localparam logic [2:0] ACCESS_ACK_D      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA_D = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/tl_slave_mem_array.sv
// Byte-masked DEPTH x 64 register array with async clear.
// Ports: clk, rst, we (lane enables), waddr, wdata, raddr, rdata (comb).
module tl_slave_mem_array #(
    parameter int DEPTH = 16,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < DW/8; b++) begin
                if (we[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tilelink_slave_mem.sv
// TileLink-UL responder with on-chip word memory and programmable latency.
// Ports: clk, rst, A channel (a_*) in with a_ready out, D channel (d_*) out with d_ready in.
module tilelink_slave_mem
    import tl_pkg::*;
#(
    parameter int TL_ADDR_WIDTH   = 64,
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int TL_SOURCE_WIDTH = 3,
    parameter int TL_SINK_WIDTH   = 3,
    parameter int TL_OPCODE_WIDTH = 3,
    parameter int TL_PARAM_WIDTH  = 3,
    parameter int TL_SIZE_WIDTH   = 8,
    parameter logic [TL_ADDR_WIDTH-1:0] BASE_ADDR = 64'h1000_0000,
    parameter int DEPTH        = 16,
    parameter int RESP_LATENCY = 2,
    parameter int SINK_ID      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]  a_param,
    input  logic [TL_ADDR_WIDTH-1:0]   a_address,
    input  logic [TL_SIZE_WIDTH-1:0]   a_size,
    input  logic [TL_STRB_WIDTH-1:0]   a_mask,
    input  logic [TL_DATA_WIDTH-1:0]   a_data,
    input  logic [TL_SOURCE_WIDTH-1:0] a_source,
    output logic                       d_valid,
    input  logic                       d_ready,
    output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
    output logic [TL_PARAM_WIDTH-1:0]  d_param,
    output logic [TL_SIZE_WIDTH-1:0]   d_size,
    output logic [TL_SINK_WIDTH-1:0]   d_sink,
    output logic [TL_SOURCE_WIDTH-1:0] d_source,
    output logic [TL_DATA_WIDTH-1:0]   d_data,
    output logic                       d_error
);

    localparam int IW  = $clog2(DEPTH);
    localparam int LM1 = (RESP_LATENCY > 0) ? RESP_LATENCY - 1 : 0;
    localparam logic [3:0] LAT_M1 = 4'(LM1);

    state_t state_q, state_d;
    logic [3:0] cnt_q;

    logic [TL_ADDR_WIDTH-1:0] offset;
    logic [IW-1:0]            idx;
    logic [TL_DATA_WIDTH-1:0] rd_data;
    logic [TL_STRB_WIDTH-1:0] we;
    logic is_get, is_put, range_err, size_err, align_err, err, accept;
    logic unused;

    assign offset    = a_address - BASE_ADDR;
    assign idx       = offset[IW+2:3];
    assign is_get    = (a_opcode == GET_A);
    assign is_put    = (a_opcode == PUT_FULL_DATA_A) ||
                       (a_opcode == PUT_PARTIAL_DATA_A);
    assign range_err = (a_address < BASE_ADDR) ||
                       (offset >= TL_ADDR_WIDTH'(DEPTH * 8));
    assign size_err  = (a_size > TL_SIZE_WIDTH'(3));

    // Only sizes 0..3 are legal; larger ones already flag size_err.
    always_comb begin
        align_err = 1'b0;
        unique case (a_size[1:0])
            2'd0:    align_err = 1'b0;
            2'd1:    align_err = a_address[0];
            2'd2:    align_err = |a_address[1:0];
            default: align_err = |a_address[2:0];
        endcase
    end

    assign err    = range_err | size_err | align_err | ~(is_get | is_put);
    assign accept = a_valid & a_ready;
    assign we     = (accept && is_put && !err) ? a_mask : '0;
    assign unused = ^{a_param, offset};

    tl_slave_mem_array #(
        .DEPTH (DEPTH),
        .DW    (TL_DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (idx),
        .wdata (a_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (RESP_LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= LAT_M1;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Response fields are captured at acceptance and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_opcode <= '0;
            d_error  <= 1'b0;
            d_source <= '0;
            d_size   <= '0;
            d_data   <= '0;
        end else if (accept) begin
            d_opcode <= is_get ? ACCESS_ACK_DATA_D : ACCESS_ACK_D;
            d_error  <= err;
            d_source <= a_source;
            d_size   <= a_size;
            d_data   <= (is_get && !err) ? rd_data : '0;
        end
    end

    assign a_ready = (state_q == IDLE) && !rst;
    assign d_valid = (state_q == RESP);
    assign d_param = '0;
    assign d_sink  = TL_SINK_WIDTH'(SINK_ID);

endmodule

// File: tb/tb_tilelink_slave_mem.sv
// Directed bench for tilelink_slave_mem: one instance with latency 2,
// one with latency 0 at a different base address.
module tb_tilelink_slave_mem;
    import tl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        a0_valid, a0_ready, d0_valid, d0_ready, d0_error;
    logic [2:0]  a0_opcode, a0_param, a0_source, d0_opcode, d0_param;
    logic [2:0]  d0_sink, d0_source;
    logic [63:0] a0_address, a0_data, d0_data;
    logic [7:0]  a0_size, a0_mask, d0_size;

    logic        a1_valid, a1_ready, d1_valid, d1_ready, d1_error;
    logic [2:0]  a1_opcode, a1_param, a1_source, d1_opcode, d1_param;
    logic [2:0]  d1_sink, d1_source;
    logic [63:0] a1_address, a1_data, d1_data;
    logic [7:0]  a1_size, a1_mask, d1_size;

    tilelink_slave_mem #(
        .BASE_ADDR    (64'h1000_0000),
        .DEPTH        (16),
        .RESP_LATENCY (2),
        .SINK_ID      (5)
    ) dut0 (
        .clk (clk), .rst (rst),
        .a_valid (a0_valid), .a_ready (a0_ready),
        .a_opcode (a0_opcode), .a_param (a0_param),
        .a_address (a0_address), .a_size (a0_size),
        .a_mask (a0_mask), .a_data (a0_data), .a_source (a0_source),
        .d_valid (d0_valid), .d_ready (d0_ready),
        .d_opcode (d0_opcode), .d_param (d0_param),
        .d_size (d0_size), .d_sink (d0_sink), .d_source (d0_source),
        .d_data (d0_data), .d_error (d0_error)
    );

    tilelink_slave_mem #(
        .BASE_ADDR    (64'h2000_0000),
        .DEPTH        (16),
        .RESP_LATENCY (0),
        .SINK_ID      (0)
    ) dut1 (
        .clk (clk), .rst (rst),
        .a_valid (a1_valid), .a_ready (a1_ready),
        .a_opcode (a1_opcode), .a_param (a1_param),
        .a_address (a1_address), .a_size (a1_size),
        .a_mask (a1_mask), .a_data (a1_data), .a_source (a1_source),
        .d_valid (d1_valid), .d_ready (d1_ready),
        .d_opcode (d1_opcode), .d_param (d1_param),
        .d_size (d1_size), .d_sink (d1_sink), .d_source (d1_source),
        .d_data (d1_data), .d_error (d1_error)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue0(input logic [2:0] op, input logic [63:0] addr,
                          input logic [7:0] size, input logic [7:0] mask,
                          input logic [63:0] data, input logic [2:0] src);
        int k = 0;
        @(negedge clk);
        a0_opcode  = op;
        a0_address = addr;
        a0_size    = size;
        a0_mask    = mask;
        a0_data    = data;
        a0_source  = src;
        a0_valid   = 1'b1;
        while (!a0_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("a_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 a0_valid = 1'b0;
    endtask

    task automatic wait_d0(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d0_valid && lat < 20);
        if (!d0_valid) chk("d_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic xact0(input logic [2:0] op, input logic [63:0] addr,
                         input logic [7:0] size, input logic [7:0] mask,
                         input logic [63:0] data, input logic [2:0] src,
                         output logic [2:0] rop, output logic [63:0] rdat,
                         output logic rerr, output logic [2:0] rsrc,
                         output int lat);
        issue0(op, addr, size, mask, data, src);
        wait_d0(lat);
        rop  = d0_opcode;
        rdat = d0_data;
        rerr = d0_error;
        rsrc = d0_source;
        d0_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  rop, rsrc;
    logic [63:0] rdat;
    logic        rerr;
    int          lat;
    int          acc_c [3];
    int          n_acc, n_rsp;
    logic        acc;

    initial begin
        a0_valid = 0; a0_opcode = 0; a0_param = 0; a0_address = 0;
        a0_size = 0; a0_mask = 0; a0_data = 0; a0_source = 0;
        a1_valid = 0; a1_opcode = 0; a1_param = 0; a1_address = 0;
        a1_size = 0; a1_mask = 0; a1_data = 0; a1_source = 0;
        d0_ready = 1; d1_ready = 1;
        acc_c = '{0, 0, 0};

        repeat (2) @(negedge clk);
        chk("rst_a_ready", a0_ready, 0);
        chk("rst_d_valid", d0_valid, 0);
        chk("rst_d_sink", d0_sink, 5);
        chk("rst_d_data", d0_data, 0);
        rst = 0;
        #1 chk("post_rst_a_ready", a0_ready, 1);

        // Put then Get
        xact0(PUT_FULL_DATA_A, 64'h1000_0000, 3, 8'hFF,
              64'hDEAD_BEEF_CAFE_BABE, 1, rop, rdat, rerr, rsrc, lat);
        chk("put_op", rop, ACCESS_ACK_D);
        chk("put_src", rsrc, 1);
        chk("put_err", rerr, 0);
        chk("put_lat", lat, 3);
        chk("put_param", d0_param, 0);
        xact0(GET_A, 64'h1000_0000, 3, 8'hFF, 0, 2,
              rop, rdat, rerr, rsrc, lat);
        chk("get_op", rop, ACCESS_ACK_DATA_D);
        chk("get_data", rdat, 64'hDEAD_BEEF_CAFE_BABE);
        chk("get_src", rsrc, 2);

        // Partial write
        xact0(PUT_PARTIAL_DATA_A, 64'h1000_0000, 3, 8'h0F,
              64'h0000_0000_1122_3344, 3, rop, rdat, rerr, rsrc, lat);
        chk("pp_err", rerr, 0);
        xact0(GET_A, 64'h1000_0000, 3, 8'h00, 0, 4,
              rop, rdat, rerr, rsrc, lat);
        chk("pp_get_data", rdat, 64'hDEAD_BEEF_1122_3344);

        // Back-pressure with a competing request
        d0_ready = 0;
        issue0(GET_A, 64'h1000_0000, 3, 8'hFF, 0, 6);
        wait_d0(lat);
        a0_opcode = PUT_FULL_DATA_A; a0_address = 64'h1000_0008;
        a0_size = 3; a0_mask = 8'hFF; a0_data = '1; a0_source = 7;
        a0_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_d_valid", d0_valid, 1);
            chk("bp_d_data", d0_data, 64'hDEAD_BEEF_1122_3344);
            chk("bp_d_src", d0_source, 6);
            chk("bp_a_ready", a0_ready, 0);
        end
        d0_ready = 1;
        @(posedge clk);
        #1 a0_valid = 0;
        @(negedge clk);
        chk("bp_after_a_ready", a0_ready, 1);
        chk("bp_after_d_valid", d0_valid, 0);
        xact0(GET_A, 64'h1000_0008, 3, 8'hFF, 0, 1,
              rop, rdat, rerr, rsrc, lat);
        chk("bp_not_written", rdat, 0);

        // Errors
        xact0(GET_A, 64'h1000_0080, 3, 8'hFF, 0, 2,
              rop, rdat, rerr, rsrc, lat);
        chk("oor_op", rop, ACCESS_ACK_DATA_D);
        chk("oor_err", rerr, 1);
        chk("oor_data", rdat, 0);
        xact0(3'd2, 64'h1000_0000, 3, 8'hFF, 0, 3,
              rop, rdat, rerr, rsrc, lat);
        chk("badop_op", rop, ACCESS_ACK_D);
        chk("badop_err", rerr, 1);
        xact0(PUT_FULL_DATA_A, 64'h1000_0004, 3, 8'hFF, '1, 4,
              rop, rdat, rerr, rsrc, lat);
        chk("misalign_err", rerr, 1);
        xact0(GET_A, 64'h1000_0000, 3, 8'hFF, 0, 5,
              rop, rdat, rerr, rsrc, lat);
        chk("misalign_nowrite", rdat, 64'hDEAD_BEEF_1122_3344);

        // Back-to-back, zero latency
        n_acc = 0;
        n_rsp = 0;
        @(negedge clk);
        a1_opcode = PUT_FULL_DATA_A; a1_size = 3; a1_mask = 8'hFF;
        a1_address = 64'h2000_0000; a1_data = 64'h33; a1_source = 3;
        a1_valid = 1;
        for (int c = 0; c < 30 && n_rsp < 3; c++) begin
            if (d1_valid) begin
                chk("b2b_src", d1_source, 64'(3 + n_rsp));
                chk("b2b_op", d1_opcode, ACCESS_ACK_D);
                chk("b2b_err", d1_error, 0);
                n_rsp++;
            end
            acc = a1_ready && a1_valid;
            if (acc && n_acc < 3) acc_c[n_acc] = c;
            @(posedge clk);
            #1;
            if (acc) begin
                n_acc++;
                if (n_acc < 3) begin
                    a1_address = 64'h2000_0000 + 64'(8 * n_acc);
                    a1_source  = 3'(3 + n_acc);
                    a1_data    = 64'(3 + n_acc);
                end else begin
                    a1_valid = 0;
                end
            end
            @(negedge clk);
        end
        chk("b2b_n_rsp", n_rsp, 3);
        chk("b2b_gap01", acc_c[1] - acc_c[0], 2);
        chk("b2b_gap12", acc_c[2] - acc_c[1], 2);

        // Reset in WAIT
        issue0(GET_A, 64'h1000_0000, 3, 8'hFF, 0, 5);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mrst_d_valid", d0_valid, 0);
        chk("mrst_a_ready", a0_ready, 0);
        chk("mrst_d_data", d0_data, 0);
        chk("mrst_d_src", d0_source, 0);
        chk("mrst_d_op", d0_opcode, 0);
        chk("mrst_d_size", d0_size, 0);
        chk("mrst_d_err", d0_error, 0);
        chk("mrst_d_sink", d0_sink, 5);
        @(negedge clk);
        rst = 0;
        #1 chk("mrst_rel_a_ready", a0_ready, 1);
        xact0(GET_A, 64'h1000_0000, 3, 8'hFF, 0, 2,
              rop, rdat, rerr, rsrc, lat);
        chk("mrst_get_data", rdat, 0);
        chk("mrst_get_src", rsrc, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
